// File: rtl/group1_pkg.sv
// Shared constants and types for the group1 accumulator ALU tile.
package group1_pkg;
    localparam int WIDTH = 8;

    localparam logic [2:0] OP_NOP  = 3'd0;
    localparam logic [2:0] OP_LOAD = 3'd1;
    localparam logic [2:0] OP_ADD  = 3'd2;
    localparam logic [2:0] OP_SUB  = 3'd3;
    localparam logic [2:0] OP_AND  = 3'd4;
    localparam logic [2:0] OP_OR   = 3'd5;
    localparam logic [2:0] OP_XOR  = 3'd6;
    localparam logic [2:0] OP_ROL  = 3'd7;

    localparam int EXEC_BIT = 3;
    localparam int OSEL_BIT = 7;

    typedef struct packed {
        logic [WIDTH-1:0] acc;
        logic             c;
        logic             z;
    } acc_state_t;
endpackage

// File: rtl/group1_alu.sv
// Combinational accumulator ALU: next acc and carry/zero from old acc and operand.
module group1_alu
    import group1_pkg::*;
#(
    parameter int W = WIDTH
) (
    input  logic [2:0]   op,
    input  logic [W-1:0] acc,
    input  logic [W-1:0] b,
    output logic [W-1:0] result,
    output logic         carry,
    output logic         zero
);
    localparam int SHW = $clog2(W);

    logic [W:0]     sum;
    logic [W:0]     diff;
    logic [2*W-1:0] rot_dbl;

    assign sum     = {1'b0, acc} + {1'b0, b};
    // top bit of the widened difference is the borrow (acc < b)
    assign diff    = {1'b0, acc} - {1'b0, b};
    assign rot_dbl = {acc, acc} << b[SHW-1:0];

    always_comb begin
        result = acc;
        carry  = 1'b0;
        case (op)
            OP_LOAD: result = b;
            OP_ADD:  {carry, result} = sum;
            OP_SUB:  {carry, result} = diff;
            OP_AND:  result = acc & b;
            OP_OR:   result = acc | b;
            OP_XOR:  result = acc ^ b;
            OP_ROL:  result = rot_dbl[2*W-1:W];
            default: result = acc;
        endcase
    end

    assign zero = (result == '0);
endmodule

// File: rtl/tt_um_group1.sv
// TinyTapeout tile: 8-bit accumulator with carry/zero flags and an acc/flag output view.
module tt_um_group1
    import group1_pkg::*;
(
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe,
    input  logic       ena,
    input  logic       clk,
    input  logic       rst_n
);
    acc_state_t st;
    logic [2:0] op;
    logic       exec;
    logic [7:0] alu_res;
    logic       alu_c;
    logic       alu_z;

    assign op   = uio_in[2:0];
    assign exec = ena & uio_in[EXEC_BIT];

    group1_alu #(.W(WIDTH)) u_alu (
        .op     (op),
        .acc    (st.acc),
        .b      (ui_in),
        .result (alu_res),
        .carry  (alu_c),
        .zero   (alu_z)
    );

    // NOP is the only executed opcode that must leave the flags alone
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            st <= '{acc: '0, c: 1'b0, z: 1'b1};
        else if (exec && op != OP_NOP)
            st <= '{acc: alu_res, c: alu_c, z: alu_z};
    end

    assign uo_out  = uio_in[OSEL_BIT] ? {6'b0, st.c, st.z} : st.acc;
    assign uio_out = 8'h00;
    assign uio_oe  = 8'h00;

    logic unused_ok;
    assign unused_ok = &{1'b0, uio_in[6:4], 1'b0};
endmodule

// File: tb/tb_tt_um_group1.sv
// Table-driven bench for tt_um_group1 with a queue scoreboard of expected acc/flag views.
module tb_tt_um_group1;
    import group1_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    tt_um_group1 dut (
        .ui_in   (ui_in),
        .uo_out  (uo_out),
        .uio_in  (uio_in),
        .uio_out (uio_out),
        .uio_oe  (uio_oe),
        .ena     (ena),
        .clk     (clk),
        .rst_n   (rst_n)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       en;
        logic       ex;
        logic [2:0] op;
        logic [7:0] b;
        logic [7:0] exp_acc;
        logic [7:0] exp_flags;
    } vec_t;

    typedef struct packed {
        logic [7:0] acc;
        logic [7:0] flags;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   n_total = 0;
    int   n_pass  = 0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%02h, want 0x%02h", name, act, exp);
    endtask

    // drive one vector, push its expectation, clock it, then pop and compare both views
    task automatic step(input string tag, input vec_t v);
        exp_t e;
        logic [7:0] u;
        u = 8'($urandom);
        ena    = v.en;
        ui_in  = v.b;
        uio_in = {1'b0, u[6:4], v.ex, v.op};
        sb.push_back('{acc: v.exp_acc, flags: v.exp_flags});
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check({tag, " sb_empty"}, 8'h01, 8'h00);
        end else begin
            e = sb.pop_front();
            uio_in[OSEL_BIT] = 1'b0;
            #1 check({tag, " acc"}, uo_out, e.acc);
            uio_in[OSEL_BIT] = 1'b1;
            #1 check({tag, " flags"}, uo_out, e.flags);
            check({tag, " bidir"}, uio_out | uio_oe, 8'h00);
        end
    endtask

    initial begin
        // {ena, exec, op, b, expected acc, expected {C,Z}}
        vecs.push_back('{1, 1, OP_LOAD, 8'hF0, 8'hF0, 8'h00});
        vecs.push_back('{1, 1, OP_ADD,  8'h20, 8'h10, 8'h02});
        vecs.push_back('{1, 1, OP_ADD,  8'hF0, 8'h00, 8'h03});
        vecs.push_back('{1, 1, OP_LOAD, 8'h05, 8'h05, 8'h00});
        vecs.push_back('{1, 1, OP_SUB,  8'h07, 8'hFE, 8'h02});
        vecs.push_back('{1, 1, OP_SUB,  8'hFE, 8'h00, 8'h01});
        vecs.push_back('{1, 1, OP_LOAD, 8'hAA, 8'hAA, 8'h00});
        vecs.push_back('{1, 1, OP_AND,  8'h0F, 8'h0A, 8'h00});
        vecs.push_back('{1, 1, OP_OR,   8'h50, 8'h5A, 8'h00});
        vecs.push_back('{1, 1, OP_XOR,  8'hFF, 8'hA5, 8'h00});
        vecs.push_back('{1, 1, OP_ROL,  8'h03, 8'h2D, 8'h00});
        vecs.push_back('{1, 1, OP_ROL,  8'hF8, 8'h2D, 8'h00});
        vecs.push_back('{1, 1, OP_LOAD, 8'h33, 8'h33, 8'h00});
        vecs.push_back('{1, 1, OP_ADD,  8'h11, 8'h44, 8'h00});
        vecs.push_back('{1, 1, OP_ADD,  8'h11, 8'h55, 8'h00});
        vecs.push_back('{1, 1, OP_ADD,  8'h11, 8'h66, 8'h00});
        vecs.push_back('{1, 1, OP_LOAD, 8'h33, 8'h33, 8'h00});
        vecs.push_back('{0, 1, OP_ADD,  8'h11, 8'h33, 8'h00});
        vecs.push_back('{1, 0, OP_ADD,  8'h11, 8'h33, 8'h00});
        vecs.push_back('{1, 1, OP_NOP,  8'hFF, 8'h33, 8'h00});
        vecs.push_back('{1, 1, OP_XOR,  8'h33, 8'h00, 8'h01});
        vecs.push_back('{1, 1, OP_NOP,  8'h00, 8'h00, 8'h01});
        vecs.push_back('{0, 1, OP_LOAD, 8'h55, 8'h00, 8'h01});
        vecs.push_back('{1, 1, OP_LOAD, 8'hC0, 8'hC0, 8'h00});
        vecs.push_back('{1, 1, OP_ADD,  8'h40, 8'h00, 8'h03});
        vecs.push_back('{1, 1, OP_AND,  8'hFF, 8'h00, 8'h01});

        // reset with random inputs, clock running
        rst_n  = 1'b0;
        ena    = 1'b1;
        ui_in  = 8'($urandom);
        uio_in = 8'($urandom) | 8'h08;
        repeat (2) @(posedge clk);
        #1 uio_in[OSEL_BIT] = 1'b0;
        #1 check("reset acc", uo_out, 8'h00);
        uio_in[OSEL_BIT] = 1'b1;
        #1 check("reset flags", uo_out, 8'h01);
        check("reset bidir", uio_out | uio_oe, 8'h00);
        uio_in = 8'h00;
        #1 rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++)
            step($sformatf("vec%0d", i), vecs[i]);

        // async reset between edges while an ADD is being executed
        step("pre_rst", '{1, 1, OP_LOAD, 8'h77, 8'h77, 8'h00});
        ena    = 1'b1;
        ui_in  = 8'h11;
        uio_in = {1'b0, 3'b000, 1'b1, OP_ADD};
        #1 rst_n = 1'b0;
        #1 check("async rst acc", uo_out, 8'h00);
        uio_in[OSEL_BIT] = 1'b1;
        #1 check("async rst flags", uo_out, 8'h01);
        rst_n = 1'b1;
        step("post_rst", '{1, 1, OP_ADD, 8'h11, 8'h11, 8'h00});

        check("sb drained", 8'(sb.size()), 8'h00);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
